load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: executes lb/lh/lw/lbu/lhu loads against a beat-wide memory read port.
// Optional feature macro: LOAD_UNIT_UNALIGNED_EN. When it is defined, misaligned half/word
// loads complete, and a load that crosses a beat boundary merges two beats.
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   req_valid/req_ready             request handshake; req_addr byte address, req_type load type
//   mem_rd_en/mem_addr              one-cycle read strobe and beat-aligned address
//   mem_rvalid/mem_rdata            returned beat
//   rsp_valid/rsp_ready             response handshake; rsp_data extended result, rsp_exc status
//   flush                           discards the in-flight load
module load_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_exc,
    input  logic              flush
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned WIN_W = 2 * DATA_W;

`ifdef LOAD_UNIT_UNALIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RD1 = 2'd1, RD2 = 2'd2, RESP = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RD1 = 2'd1, RESP = 2'd3} state_e;
`endif

    state_e            state_q;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        type_q;
    logic              drop_q;
    logic              req_ready_q;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [1:0]        rsp_exc_q;
`ifdef LOAD_UNIT_UNALIGNED_EN
    logic              cross_q;
    logic [DATA_W-1:0] beat0_q;
`endif

    // Sign/zero extension of the selected lane according to the load type
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] ty);
        logic [31:0] r;
        case (ty)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'd0, raw[7:0]};
            3'b101:  r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Request decode
    logic [OFF_W-1:0]  req_off_c;
    logic              req_illegal_c;
    logic [ADDR_W-1:0] req_base_c;
    assign req_off_c     = req_addr[OFF_W-1:0];
    assign req_illegal_c = (req_type[1:0] == 2'b10) || (req_type == 3'b111);
    assign req_base_c    = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

`ifdef LOAD_UNIT_UNALIGNED_EN
    localparam int unsigned END_W = OFF_W + 1;
    logic [3:0]       req_size_c;
    logic [END_W-1:0] req_end_c;
    logic             req_cross_c;
    always_comb begin
        req_size_c = 4'd4;
        case (req_type[1:0])
            2'b00:   req_size_c = 4'd1;
            2'b01:   req_size_c = 4'd2;
            default: req_size_c = 4'd4;
        endcase
    end
    // One past the last byte touched, relative to the beat base
    assign req_end_c   = END_W'(req_off_c) + END_W'(req_size_c);
    assign req_cross_c = req_end_c > END_W'(BYTES);
`else
    logic req_misal_c;
    assign req_misal_c = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_type[1:0] == 2'b11) && (req_addr[1:0] != 2'b00));
`endif

    // Lane select: a two-beat window {high, low} shifted down by the byte offset
    logic [WIN_W-1:0] win_c;
    logic [31:0]      result_c;
    always_comb begin
`ifdef LOAD_UNIT_UNALIGNED_EN
        win_c = (state_q == RD2) ? {mem_rdata, beat0_q} : {{DATA_W{1'b0}}, mem_rdata};
`else
        win_c = {{DATA_W{1'b0}}, mem_rdata};
`endif
        result_c = extend(32'(win_c >> {off_q, 3'b000}), type_q);
    end

    // A beat counts only once the read strobe has been issued
    logic beat_c;
    logic drop_c;
    assign beat_c = mem_rvalid && !mem_rd_en_q;
    assign drop_c = drop_q || flush;

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            off_q       <= '0;
            type_q      <= '0;
            drop_q      <= 1'b0;
            req_ready_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_exc_q   <= 2'b00;
`ifdef LOAD_UNIT_UNALIGNED_EN
            cross_q     <= 1'b0;
            beat0_q     <= '0;
`endif
        end else begin
            mem_rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        off_q       <= req_off_c;
                        type_q      <= req_type;
                        drop_q      <= 1'b0;
`ifdef LOAD_UNIT_UNALIGNED_EN
                        cross_q     <= req_cross_c;
`endif
                        if (req_illegal_c) begin
                            rsp_exc_q  <= 2'b10;
                            rsp_data_q <= '0;
                            state_q    <= RESP;
`ifndef LOAD_UNIT_UNALIGNED_EN
                        end else if (req_misal_c) begin
                            rsp_exc_q  <= 2'b01;
                            rsp_data_q <= '0;
                            state_q    <= RESP;
`endif
                        end else begin
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= req_base_c;
                            state_q     <= RD1;
                        end
                    end
                end
                RD1: begin
                    if (beat_c) begin
                        if (drop_c) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                            drop_q      <= 1'b0;
                        end
`ifdef LOAD_UNIT_UNALIGNED_EN
                        else if (cross_q) begin
                            beat0_q     <= mem_rdata;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(BYTES);
                            state_q     <= RD2;
                        end
`endif
                        else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= result_c;
                            rsp_exc_q   <= 2'b00;
                            state_q     <= RESP;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
`ifdef LOAD_UNIT_UNALIGNED_EN
                RD2: begin
                    if (beat_c) begin
                        if (drop_c) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                            drop_q      <= 1'b0;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= result_c;
                            rsp_exc_q   <= 2'b00;
                            state_q     <= RESP;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
`endif
                RESP: begin
                    // Exception responses arrive here with rsp_valid still low and raise it next cycle
                    if (flush || (rsp_valid_q && rsp_ready)) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_exc_q   <= 2'b00;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_exc   = rsp_exc_q;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed plus randomized checks of load_unit against a byte-array memory model.
`timescale 1ns/1ps
module tb_load_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_type;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_exc;
    logic          flush;

    logic          mem_rv_q = 1'b0;
    logic          stray_rv;
    assign mem_rvalid = mem_rv_q | stray_rv;

    load_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_exc    (rsp_exc),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory with a programmable read latency (in cycles)
    logic [7:0]  mem_b [0:1023];
    int          mem_lat = 1;
    int          rd_count = 0;
    logic [31:0] rd_a0 = '0;
    logic [31:0] rd_a1 = '0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] beat_at(input logic [31:0] a);
        int b;
        b = int'(a[9:0]) & ~3;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    always @(posedge clk) begin
        mem_rv_q <= 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                mem_rv_q  <= 1'b1;
                mem_rdata <= beat_at(paddr);
                pend      <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
        if (mem_rd_en) begin
            rd_count <= rd_count + 1;
            rd_a0    <= rd_a1;
            rd_a1    <= mem_addr;
            if (mem_lat <= 1) begin
                mem_rv_q  <= 1'b1;
                mem_rdata <= beat_at(mem_addr);
            end else begin
                pend  <= 1'b1;
                pcnt  <= mem_lat - 1;
                paddr <= mem_addr;
            end
        end
    end

    // Reference: what a load should return, built directly from memory bytes
    function automatic void model(input logic [31:0] a, input logic [2:0] t,
                                  output logic [31:0] d, output logic [1:0] e, output int n);
        int sz;
        int ai;
        longint unsigned v;
        d = '0;
        e = 2'b00;
        n = 0;
        if (t == 3'b010 || t == 3'b110 || t == 3'b111) begin
            e = 2'b10;
            return;
        end
        sz = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
        ai = int'(a[9:0]);
`ifndef LOAD_UNIT_UNALIGNED_EN
        if (ai % sz != 0) begin
            e = 2'b01;
            return;
        end
`endif
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (64'(mem_b[ai+i]) << (8*i));
        if (t[2] == 1'b0 && sz < 4 && v >= (64'd1 << (8*sz-1)))
            v = v + (64'd1 << 32) - (64'd1 << (8*sz));
        d = v[31:0];
        n = ((ai % 4) + sz > 4) ? 2 : 1;
    endfunction

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_data;
    logic [1:0]  last_exc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_b[a+i] = w[8*i +: 8];
    endtask

    // One complete load: issue, wait for response, hold, then handshake
    task automatic run_load(input logic [31:0] a, input logic [2:0] t, input int hold, input string tag);
        logic [31:0] ed;
        logic [1:0]  ee;
        int          en;
        int          cyc;
        int          rc0;
        int          lat_exp;
        model(a, t, ed, ee, en);
        lat_exp = (ee != 2'b00) ? 2 : 1 + en * (mem_lat + 1);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        rc0 = rd_count;
        req_valid = 1'b1;
        req_addr  = a;
        req_type  = t;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat_exp));
        chk({tag, "_data"}, rsp_data, ed);
        chk({tag, "_exc"}, 32'(rsp_exc), 32'(ee));
        chk({tag, "_reads"}, 32'(rd_count - rc0), 32'(en));
        last_data = rsp_data;
        last_exc  = rsp_exc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_d"}, rsp_data, ed);
            chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done_v"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [31:0] ra;
        logic [2:0]  rt;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_type  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        stray_rv  = 1'b0;
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_exc", 32'(rsp_exc), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Lane select and extension on a known word
        mem_lat = 1;
        set_word(32'h100, 32'h8899AABB);
        run_load(32'h101, 3'b000, 0, "lb101");
        chk("lb101_val", last_data, 32'hFFFFFFAA);
        run_load(32'h103, 3'b100, 0, "lbu103");
        chk("lbu103_val", last_data, 32'h00000088);
        run_load(32'h102, 3'b001, 0, "lh102");
        chk("lh102_val", last_data, 32'hFFFF8899);
        run_load(32'h100, 3'b011, 0, "lw100");
        chk("lw100_val", last_data, 32'h8899AABB);

        // Illegal type
        run_load(32'h100, 3'b111, 1, "ill");
        chk("ill_val", last_data, 32'd0);
        chk("ill_exc_val", 32'(last_exc), 32'd2);

        // Back-pressure on the response
        run_load(32'h100, 3'b011, 5, "hold5");

        // Misaligned word across a beat boundary
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        run_load(32'h102, 3'b011, 0, "lw102");
`ifdef LOAD_UNIT_UNALIGNED_EN
        chk("lw102_val", last_data, 32'h66554433);
        chk("lw102_rd0", rd_a0, 32'h100);
        chk("lw102_rd1", rd_a1, 32'h104);
`else
        chk("lw102_exc_val", 32'(last_exc), 32'd1);
`endif

        // Randomized loads with varying latency and back-pressure
        for (int k = 0; k < 40; k++) begin
            ra      = 32'($urandom_range(0, 511));
            rt      = 3'($urandom_range(0, 7));
            mem_lat = int'($urandom_range(1, 3));
            run_load(ra, rt, int'($urandom_range(0, 2)), "rnd");
        end

        // Flush while waiting for a slow beat
        mem_lat   = 3;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_type  = 3'b011;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cyc = 0;
        while (mem_rvalid !== 1'b1 && cyc < 10) begin
            chk("flush_rd1_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk("flush_rd1_beat_seen", 32'(mem_rvalid), 32'd1);
        chk("flush_rd1_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("flush_rd1_ready", 32'(req_ready), 32'd1);
        chk("flush_rd1_no_rsp2", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("flush_rd1_no_rsp3", 32'(rsp_valid), 32'd0);

        // Flush while the response is pending
        mem_lat   = 1;
        req_valid = 1'b1;
        req_addr  = 32'h103;
        req_type  = 3'b100;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_resp_valid", 32'(rsp_valid), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_resp_dropped", 32'(rsp_valid), 32'd0);
        chk("flush_resp_ready", 32'(req_ready), 32'd1);

        // Flush together with rsp_ready
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_type  = 3'b011;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_hs_valid", 32'(rsp_valid), 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        rsp_ready = 1'b0;
        chk("flush_hs_v0", 32'(rsp_valid), 32'd0);
        chk("flush_hs_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("flush_hs_nodup", 32'(rsp_valid), 32'd0);

        // Reset during a read, then a stray beat
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_type  = 3'b011;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("rrd1_req_ready", 32'(req_ready), 32'd0);
        chk("rrd1_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rrd1_mem_addr", mem_addr, 32'd0);
        chk("rrd1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rrd1_rsp_data", rsp_data, 32'd0);
        chk("rrd1_rsp_exc", 32'(rsp_exc), 32'd0);
        reset    = 1'b1;
        stray_rv = 1'b1;
        @(negedge clk);
        stray_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rrd1_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("rrd1_idle", 32'(req_ready), 32'd1);
        run_load(32'h101, 3'b001, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
